// File: rtl/ysyx_041461_pipe_ctrl.sv
// Pipeline sequencing controller: hold/bubble chain, stage valid bits, PC control,
// trap drain FSM and saturating stall counter for the IF/IF2/ID/EXE/MEM/WB pipe.
module ysyx_041461_pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_ready,
    input  logic             mem_ready,
    input  logic             mem_access,
    input  logic             id_conflict,
    input  logic             exe_conflict,
    input  logic             mem_conflict,
    input  logic             trap_if,
    input  logic             trap_if2,
    input  logic             trap_id,
    input  logic             trap_exe,
    input  logic             trap_mem,
    input  logic             wb_trap,
    input  logic             id_redirect,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             en_if2,
    output logic             en_id,
    output logic             en_exe,
    output logic             en_mem,
    output logic             en_wb,
    output logic             v_if2,
    output logic             v_id,
    output logic             v_exe,
    output logic             v_mem,
    output logic             v_wb,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        REDIR = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             v_if2_q, v_if2_d;
    logic             v_id_q, v_id_d;
    logic             v_exe_q, v_exe_d;
    logic             v_mem_q, v_mem_d;
    logic             v_wb_q, v_wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hold_mem, hold_exe, hold_id, hold_if2, hold_if;
    logic trap_any, redirect_ok;

    // Holds propagate upstream: a stalled stage freezes every older-source stage behind it.
    assign hold_mem = v_mem_q & ((mem_access & ~mem_ready) | mem_conflict);
    assign hold_exe = hold_mem | (v_exe_q & exe_conflict);
    assign hold_id  = hold_exe | (v_id_q & id_conflict);
    assign hold_if2 = hold_id;
    assign hold_if  = hold_if2 | ~if_ready;

    assign en_if2 = ~hold_if;
    assign en_id  = ~hold_if2;
    assign en_exe = ~hold_id;
    assign en_mem = ~hold_exe;
    assign en_wb  = ~hold_mem;

    assign trap_any    = trap_if | trap_if2 | trap_id | trap_exe | trap_mem | wb_trap;
    assign redirect_ok = (state_q == RUN) & ~trap_any & id_redirect & v_id_q & ~hold_id;

    always_comb begin
        state_d = state_q;
        pc_en   = 1'b0;
        pc_sel  = 2'd0;

        v_if2_d = hold_if2 ? v_if2_q : (if_ready & ~trap_if);
        v_id_d  = hold_id  ? v_id_q  : (v_if2_q & ~trap_if2);
        v_exe_d = hold_exe ? v_exe_q : (hold_id  ? 1'b0 : (v_id_q  & ~trap_id));
        v_mem_d = hold_mem ? v_mem_q : (hold_exe ? 1'b0 : (v_exe_q & ~trap_exe));
        v_wb_d  = hold_mem ? 1'b0    : (v_mem_q & ~trap_mem);

        unique case (state_q)
            RUN: begin
                pc_en = ~hold_if & ~trap_any;
                if (redirect_ok) pc_sel = 2'd1;
                if (wb_trap)       state_d = REDIR;
                else if (trap_any) state_d = DRAIN;
            end
            DRAIN: begin
                if (wb_trap) state_d = REDIR;
            end
            REDIR: begin
                pc_en   = 1'b1;
                pc_sel  = 2'd2;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        // Once a trap is seen nothing new is fetched, so IF2 only ever receives bubbles.
        if ((state_q != RUN) || trap_any) v_if2_d = 1'b0;

        if (redirect_ok) begin
            v_if2_d = 1'b0;
            v_id_d  = 1'b0;
        end

        if (state_q == REDIR) begin
            v_if2_d = 1'b0;
            v_id_d  = 1'b0;
            v_exe_d = 1'b0;
            v_mem_d = 1'b0;
            v_wb_d  = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == RUN) && hold_if && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            v_if2_q <= 1'b0;
            v_id_q  <= 1'b0;
            v_exe_q <= 1'b0;
            v_mem_q <= 1'b0;
            v_wb_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            v_if2_q <= v_if2_d;
            v_id_q  <= v_id_d;
            v_exe_q <= v_exe_d;
            v_mem_q <= v_mem_d;
            v_wb_q  <= v_wb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign v_if2     = v_if2_q;
    assign v_id      = v_id_q;
    assign v_exe     = v_exe_q;
    assign v_mem     = v_mem_q;
    assign v_wb      = v_wb_q;
    assign state     = state_q;
    assign stall_cnt = cnt_q;

endmodule
